// File: rtl/index_op_pkg.sv
// Shared encodings for the indexed memory-op sequencer: op codes, FSM states, flag layout.
// Small helpers keep op classification and displacement sign-extension in one place.
package index_op_pkg;

  typedef enum logic [2:0] {
    OP_LD_IDX_NN  = 3'd0,
    OP_LD_IDX_MNN = 3'd1,
    OP_LD_MNN_IDX = 3'd2,
    OP_INC_MD     = 3'd3,
    OP_DEC_MD     = 3'd4,
    OP_LD_MD_N    = 3'd5
  } op_e;

  localparam logic [2:0] OP_MAX = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH_LO = 4'd1,
    ST_FETCH_HI = 4'd2,
    ST_READ_LO  = 4'd3,
    ST_READ_HI  = 4'd4,
    ST_MODIFY   = 4'd5,
    ST_WRITE_LO = 4'd6,
    ST_WRITE_HI = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

  // Bit order on the flags port: {S, Z, H, PV, N}; carry is never touched.
  typedef struct packed {
    logic s;
    logic z;
    logic h;
    logic pv;
    logic n;
  } flags_t;

  function automatic logic op_supported(input logic [2:0] op);
    return op <= OP_MAX;
  endfunction

  function automatic logic op_loads_idx(input op_e op);
    return (op == OP_LD_IDX_NN) || (op == OP_LD_IDX_MNN);
  endfunction

  function automatic logic op_is_incdec(input op_e op);
    return (op == OP_INC_MD) || (op == OP_DEC_MD);
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] d);
    return {{8{d[7]}}, d};
  endfunction

endpackage

// File: rtl/index_incdec_alu.sv
// 8-bit combinational increment/decrement with S/Z/H/PV/N flag generation.
// Overflow is flagged when the result crosses the signed boundary (0x7F->0x80 or 0x80->0x7F).
module index_incdec_alu
  import index_op_pkg::*;
(
  input  logic [7:0] m_i,
  input  logic       dec_i,
  output logic [7:0] r_o,
  output flags_t     flags_o
);

  always_comb begin
    r_o        = dec_i ? (m_i - 8'd1) : (m_i + 8'd1);
    flags_o.s  = r_o[7];
    flags_o.z  = (r_o == 8'h00);
    flags_o.h  = dec_i ? (m_i[3:0] == 4'h0) : (m_i[3:0] == 4'hF);
    flags_o.pv = dec_i ? (r_o == 8'h7F) : (r_o == 8'h80);
    flags_o.n  = dec_i;
  end

endmodule

// File: rtl/index_op_sequencer.sv
// Sequences IX/IY memory ops: operand fetch from pc, optional read/modify/write at nn or idx+d, index writeback.
// Memory outputs are decoded from the state register, so they stay stable for as long as mem_ack is withheld.
module index_op_sequencer
  import index_op_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        is_Y,
  input  logic [15:0] ix,
  input  logic [15:0] iy,
  input  logic [15:0] pc,
  output logic        pc_inc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        ix_we,
  output logic        iy_we,
  output logic [15:0] idx_wdata,
  output logic        flag_we,
  output logic [4:0]  flags,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        is_y_q, is_y_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  opnd_lo_q, opnd_lo_d;
  logic [7:0]  opnd_hi_q, opnd_hi_d;
  logic [7:0]  rd_lo_q, rd_lo_d;
  logic [7:0]  rd_hi_q, rd_hi_d;

  logic        xfer;
  logic [15:0] nn, nn_p1, ea;
  logic [7:0]  alu_r;
  flags_t      alu_flags;

  // opnd_lo doubles as the displacement d for the indexed forms.
  assign nn    = {opnd_hi_q, opnd_lo_q};
  assign nn_p1 = nn + 16'd1;
  assign ea    = idx_q + sext8(opnd_lo_q);
  assign xfer  = mem_req & mem_ack;

  index_incdec_alu u_alu (
    .m_i     (rd_lo_q),
    .dec_i   (op_q == OP_DEC_MD),
    .r_o     (alu_r),
    .flags_o (alu_flags)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    is_y_d    = is_y_q;
    idx_d     = idx_q;
    opnd_lo_d = opnd_lo_q;
    opnd_hi_d = opnd_hi_q;
    rd_lo_d   = rd_lo_q;
    rd_hi_d   = rd_hi_q;
    case (state_q)
      ST_IDLE: begin
        if (start && op_supported(op)) begin
          op_d    = op_e'(op);
          is_y_d  = is_Y;
          idx_d   = is_Y ? iy : ix;
          state_d = ST_FETCH_LO;
        end
      end
      ST_FETCH_LO: begin
        if (xfer) begin
          opnd_lo_d = mem_rdata;
          state_d   = op_is_incdec(op_q) ? ST_READ_LO : ST_FETCH_HI;
        end
      end
      ST_FETCH_HI: begin
        if (xfer) begin
          opnd_hi_d = mem_rdata;
          case (op_q)
            OP_LD_IDX_NN:  state_d = ST_DONE;
            OP_LD_IDX_MNN: state_d = ST_READ_LO;
            default:       state_d = ST_WRITE_LO;
          endcase
        end
      end
      ST_READ_LO: begin
        if (xfer) begin
          rd_lo_d = mem_rdata;
          state_d = (op_q == OP_LD_IDX_MNN) ? ST_READ_HI : ST_MODIFY;
        end
      end
      ST_READ_HI: begin
        if (xfer) begin
          rd_hi_d = mem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_MODIFY:   state_d = ST_WRITE_LO;
      ST_WRITE_LO: begin
        if (xfer) state_d = (op_q == OP_LD_MNN_IDX) ? ST_WRITE_HI : ST_DONE;
      end
      ST_WRITE_HI: begin
        if (xfer) state_d = ST_DONE;
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_inc    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    ix_we     = 1'b0;
    iy_we     = 1'b0;
    idx_wdata = 16'h0000;
    flag_we   = 1'b0;
    flags     = 5'b00000;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_FETCH_LO, ST_FETCH_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        pc_inc   = mem_ack;
      end
      ST_READ_LO: begin
        mem_req  = 1'b1;
        mem_addr = (op_q == OP_LD_IDX_MNN) ? nn : ea;
      end
      ST_READ_HI: begin
        mem_req  = 1'b1;
        mem_addr = nn_p1;
      end
      ST_MODIFY: begin
        flag_we = 1'b1;
        flags   = alu_flags;
      end
      ST_WRITE_LO: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        case (op_q)
          OP_LD_MNN_IDX: begin
            mem_addr  = nn;
            mem_wdata = idx_q[7:0];
          end
          OP_LD_MD_N: begin
            mem_addr  = ea;
            mem_wdata = opnd_hi_q;
          end
          default: begin
            mem_addr  = ea;
            mem_wdata = alu_r;
          end
        endcase
      end
      ST_WRITE_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = nn_p1;
        mem_wdata = idx_q[15:8];
      end
      ST_DONE: begin
        done = 1'b1;
        if (op_loads_idx(op_q)) begin
          ix_we     = ~is_y_q;
          iy_we     = is_y_q;
          idx_wdata = (op_q == OP_LD_IDX_NN) ? nn : {rd_hi_q, rd_lo_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LD_IDX_NN;
      is_y_q    <= 1'b0;
      idx_q     <= 16'h0000;
      opnd_lo_q <= 8'h00;
      opnd_hi_q <= 8'h00;
      rd_lo_q   <= 8'h00;
      rd_hi_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      is_y_q    <= is_y_d;
      idx_q     <= idx_d;
      opnd_lo_q <= opnd_lo_d;
      opnd_hi_q <= opnd_hi_d;
      rd_lo_q   <= rd_lo_d;
      rd_hi_q   <= rd_hi_d;
    end
  end

endmodule

// File: tb/tb_index_op_sequencer.sv
// Bench for index_op_sequencer: directed scenarios plus random ops against a transaction-level reference model.
`timescale 1ns/1ps
module tb_index_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        is_Y = 1'b0;
  logic [15:0] ix = 16'h0, iy = 16'h0, pc = 16'h0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h0;
  logic        pc_inc, mem_req, mem_we, ix_we, iy_we, flag_we, busy, done;
  logic [15:0] mem_addr, idx_wdata;
  logic [7:0]  mem_wdata;
  logic [4:0]  flags;

  index_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .is_Y(is_Y),
    .ix(ix), .iy(iy), .pc(pc), .pc_inc(pc_inc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ix_we(ix_we), .iy_we(iy_we), .idx_wdata(idx_wdata),
    .flag_we(flag_we), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int wait_cnt = 0, cur_delay = 0, fixed_delay = 0;
  bit rand_delay = 1'b0;

  logic        log_we[$];
  logic [15:0] log_addr[$];
  logic [7:0]  log_wd[$];
  int pc_inc_cnt, done_cnt, ix_we_cnt, iy_we_cnt, flag_we_cnt, busy_cnt, stab_err, pulse_err;
  int start_cyc, done_cyc;
  logic [15:0] idx_val;
  logic [4:0]  flag_val;

  logic        exp_we[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_wd[$];
  int          exp_fetch, exp_reg;
  logic [15:0] exp_idx;
  bit          exp_flag_v;
  logic [4:0]  exp_flags;

  bit          prev_wait = 1'b0;
  logic        p_we;
  logic [15:0] p_addr;
  logic [7:0]  p_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_delay(input bit r, input int d);
    rand_delay  = r;
    fixed_delay = d;
    cur_delay   = r ? int'($urandom_range(0, d)) : d;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: acks after cur_delay wait cycles, junk on rdata otherwise.
  initial forever begin
    @(posedge clk);
    #2;
    if (mem_req && rst_n) begin
      if (wait_cnt >= cur_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      wait_cnt  = 0;
    end
  end

  // Observer at the falling edge: logs completed transactions and output pulses.
  initial forever begin
    @(negedge clk);
    if (prev_wait && mem_req)
      if (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd) stab_err++;
    prev_wait = mem_req && !mem_ack;
    p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
    if (pc_inc && !(mem_req && mem_ack && !mem_we)) pulse_err++;
    if (mem_req && mem_ack) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_wd.push_back(mem_wdata);
      if (mem_we) mem[mem_addr] = mem_wdata;
      wait_cnt  = 0;
      cur_delay = rand_delay ? int'($urandom_range(0, fixed_delay)) : fixed_delay;
    end
    if (pc_inc) begin pc_inc_cnt++; pc = pc + 16'd1; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ix_we) begin ix_we_cnt++; idx_val = idx_wdata; end
    if (iy_we) begin iy_we_cnt++; idx_val = idx_wdata; end
    if (flag_we) begin flag_we_cnt++; flag_val = flags; end
    if (busy) busy_cnt++;
  end

  task automatic clear_logs();
    log_we.delete(); log_addr.delete(); log_wd.delete();
    pc_inc_cnt = 0; done_cnt = 0; ix_we_cnt = 0; iy_we_cnt = 0;
    flag_we_cnt = 0; busy_cnt = 0; stab_err = 0; pulse_err = 0;
    idx_val = 16'h0; flag_val = 5'h0;
  endtask

  task automatic add(input logic we, input logic [15:0] a, input logic [7:0] wd);
    exp_we.push_back(we); exp_addr.push_back(a); exp_wd.push_back(wd);
  endtask

  // Reference: the ordered list of bus transactions and side effects an op must produce.
  task automatic model(input int o, input bit y, input logic [15:0] ixv, input logic [15:0] iyv,
                       input logic [15:0] pcv);
    logic [15:0] idx, pc1, nn, nn1, ea;
    logic [7:0]  b0, b1, m, r;
    int          dval;
    exp_we.delete(); exp_addr.delete(); exp_wd.delete();
    idx  = y ? iyv : ixv;
    pc1  = pcv + 16'd1;
    b0   = mem[pcv];
    b1   = mem[pc1];
    nn   = {b1, b0};
    nn1  = nn + 16'd1;
    dval = (b0 >= 8'd128) ? int'(b0) - 256 : int'(b0);
    ea   = 16'((int'(idx) + dval + 65536) % 65536);
    exp_reg = 0; exp_flag_v = 1'b0; exp_fetch = 2; exp_idx = 16'h0; exp_flags = 5'h0;
    add(1'b0, pcv, 8'h0);
    case (o)
      0: begin
        add(1'b0, pc1, 8'h0);
        exp_reg = y ? 2 : 1; exp_idx = nn;
      end
      1: begin
        add(1'b0, pc1, 8'h0); add(1'b0, nn, 8'h0); add(1'b0, nn1, 8'h0);
        exp_reg = y ? 2 : 1; exp_idx = {mem[nn1], mem[nn]};
      end
      2: begin
        add(1'b0, pc1, 8'h0); add(1'b1, nn, idx[7:0]); add(1'b1, nn1, idx[15:8]);
      end
      3, 4: begin
        exp_fetch = 1;
        m = mem[ea];
        r = (o == 3) ? 8'((int'(m) + 1) % 256) : 8'((int'(m) + 255) % 256);
        add(1'b0, ea, 8'h0); add(1'b1, ea, r);
        exp_flag_v = 1'b1;
        exp_flags  = {r >= 8'd128, r == 8'd0,
                      (o == 3) ? ((m % 8'd16) == 8'd15) : ((m % 8'd16) == 8'd0),
                      (o == 3) ? (m == 8'd127) : (m == 8'd128),
                      o == 4};
      end
      default: begin
        add(1'b0, pc1, 8'h0); add(1'b1, ea, b1);
      end
    endcase
  endtask

  task automatic compare(input string name, input int lat);
    check({name, "/ntxn"}, log_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      check($sformatf("%s/txn%0d_addr", name, i), log_addr[i], exp_addr[i]);
      check($sformatf("%s/txn%0d_we", name, i), log_we[i], exp_we[i]);
      if (exp_we[i]) check($sformatf("%s/txn%0d_wdata", name, i), log_wd[i], exp_wd[i]);
    end
    check({name, "/pc_inc"}, pc_inc_cnt, exp_fetch);
    check({name, "/done_cnt"}, done_cnt, 1);
    check({name, "/ix_we"}, ix_we_cnt, (exp_reg == 1) ? 1 : 0);
    check({name, "/iy_we"}, iy_we_cnt, (exp_reg == 2) ? 1 : 0);
    if (exp_reg != 0) check({name, "/idx_wdata"}, idx_val, exp_idx);
    check({name, "/flag_we"}, flag_we_cnt, exp_flag_v ? 1 : 0);
    if (exp_flag_v) check({name, "/flags"}, flag_val, exp_flags);
    check({name, "/stable"}, stab_err, 0);
    check({name, "/pc_inc_pulse"}, pulse_err, 0);
    check({name, "/busy_cycles"}, busy_cnt, lat);
    check({name, "/idle_after"}, busy, 1'b0);
  endtask

  // Caller is positioned just after a rising edge; start is sampled at the next one.
  task automatic run_op(input string name, input int o, input bit y, input bit mid_start,
                        output int lat);
    int n;
    model(o, y, ix, iy, pc);
    clear_logs();
    start_cyc = cyc; op = 3'(o); is_Y = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); is_Y = 1'($urandom);
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      start = mid_start && (n == 2);
      ix = 16'($urandom); iy = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({name, "/finished"}, n < 400, 1'b1);
    lat = done_cyc - start_cyc;
    repeat (2) @(posedge clk);
    #1;
    compare(name, lat);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "/ctl"}, {pc_inc, mem_req, mem_we, ix_we, iy_we, flag_we, busy, done}, 0);
    check({tag, "/addr_wd"}, {mem_addr, mem_wdata}, 0);
    check({tag, "/idx_flags"}, {idx_wdata, flags}, 0);
  endtask

  initial begin
    int lat, n, nwr;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");

    // LD IX,nn right after reset release; start cycle is cycle 1, done lands in cycle 4.
    pc = 16'h0100; mem[16'h0100] = 8'h34; mem[16'h0101] = 8'h12; ix = 16'h5555;
    set_delay(1'b0, 0);
    rst_n = 1'b1;
    run_op("r029", 0, 1'b0, 1'b0, lat);
    check("r029/latency", lat, 3);
    check("r029/idx", idx_val, 16'h1234);
    check("r029/pc_incs", pc_inc_cnt, 2);

    @(posedge clk); #1;
    pc = 16'h0200; mem[16'h0200] = 8'hFE; iy = 16'h0005; mem[16'h0003] = 8'h7F;
    run_op("r030", 3, 1'b1, 1'b0, lat);
    check("r030/latency", lat, 5);
    check("r030/rd_addr", (log_addr.size() > 1) ? log_addr[1] : 16'h0, 16'h0003);
    check("r030/mem", mem[16'h0003], 8'h80);
    check("r030/flags", flag_val, 5'b10110);

    @(posedge clk); #1;
    pc = 16'h2000; mem[16'h2000] = 8'hFF; mem[16'h2001] = 8'hFF; ix = 16'hBEEF;
    set_delay(1'b0, 3);
    run_op("r031", 2, 1'b0, 1'b0, lat);
    check("r031/latency", lat, 17);
    check("r031/mem_ffff", mem[16'hFFFF], 8'hEF);
    check("r031/mem_0000", mem[16'h0000], 8'hBE);

    @(posedge clk); #1;
    pc = 16'h3000; mem[16'h3000] = 8'h10; ix = 16'h1000; mem[16'h1010] = 8'h00;
    set_delay(1'b0, 2);
    run_op("r032", 4, 1'b0, 1'b1, lat);
    check("r032/latency", lat, 11);
    check("r032/mem", mem[16'h1010], 8'hFF);
    check("r032/flags", flag_val, 5'b10101);

    // Reserved op codes must leave the block idle.
    set_delay(1'b0, 0);
    @(posedge clk); #1;
    clear_logs();
    op = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rsvd/busy", busy_cnt, 0);
    check("rsvd/done", done_cnt, 0);
    check("rsvd/txns", log_addr.size(), 0);

    // Reset asserted while the LD (IX+d),n write is waiting for its ack.
    pc = 16'h4000; ix = 16'h0800;
    set_delay(1'b0, 5);
    clear_logs();
    op = 3'd5; is_Y = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(mem_req && mem_we) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("r033/reached_write", n < 100, 1'b1);
    rst_n = 1'b0;
    #1;
    check("r033/mem_req", mem_req, 1'b0);
    check("r033/busy", busy, 1'b0);
    outputs_zero("r033/outs");
    repeat (3) @(posedge clk);
    #1;
    nwr = 0;
    foreach (log_we[i]) if (log_we[i]) nwr++;
    check("r033/no_write", nwr, 0);
    check("r033/no_done", done_cnt, 0);
    set_delay(1'b0, 0);
    rst_n = 1'b1;
    run_op("r033_rerun", 5, 1'b0, 1'b0, lat);
    check("r033_rerun/latency", lat, 4);

    set_delay(1'b1, 3);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      pc = 16'($urandom); ix = 16'($urandom); iy = 16'($urandom);
      run_op($sformatf("rnd%0d", i), int'($urandom_range(0, 5)), 1'($urandom),
             $urandom_range(0, 3) == 0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/index_op_sequencer.md
INDEX_OP_SEQUENCER -- requirements
Module: index_op_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to run an index op; sampled only in IDLE.
REQ-004 SHALL have port op, input, 3: 0 LD_IDX_NN, 1 LD_IDX_MNN, 2 LD_MNN_IDX, 3 INC_MD, 4 DEC_MD, 5 LD_MD_N; 6/7 reserved.
REQ-005 SHALL have port is_Y, input, 1: 0 selects IX, 1 selects IY; latched with op at start.
REQ-006 SHALL have ports ix, iy, input, 16 each: current index register values.
REQ-007 SHALL have port pc, input, 16, operand fetch address.
REQ-008 SHALL have port pc_inc, output, 1, one-cycle pulse per accepted operand fetch.
REQ-009 SHALL have ports mem_req (1), mem_we (1), mem_addr (16), mem_wdata (8), all outputs: memory request.
REQ-010 SHALL have ports mem_ack (1) and mem_rdata (8), inputs: completion and read data.
REQ-011 SHALL have ports ix_we, iy_we (1 each) and idx_wdata (16), outputs: index register write.
REQ-012 SHALL have ports flag_we (1) and flags (5: S,Z,H,PV,N), outputs; C is never written.
REQ-013 SHALL have ports busy and done, outputs, 1 each.

Function
REQ-014 SHALL use states IDLE, FETCH_LO, FETCH_HI, READ_LO, READ_HI, MODIFY, WRITE_LO, WRITE_HI, DONE.
REQ-015 SHALL, in IDLE with start=1 and op<=5, latch op, is_Y and the selected index value, then enter FETCH_LO next cycle; op 6/7 SHALL be ignored (stay IDLE, no done).
REQ-016 SHALL treat a memory transaction as complete on the edge where mem_req=1 and mem_ack=1; mem_addr, mem_we, mem_wdata SHALL hold stable while mem_req=1 and mem_ack=0.
REQ-017 SHALL drive mem_addr=pc, mem_we=0 in FETCH states and pulse pc_inc on the completing cycle only.
REQ-018 SHALL sequence per op (each arrow on completion):
  LD_IDX_NN: FETCH_LO(lo) -> FETCH_HI(hi) -> DONE, writing idx_wdata={hi,lo}.
  LD_IDX_MNN: FETCH_LO -> FETCH_HI -> READ_LO @nn -> READ_HI @nn+1 -> DONE, writing {hi,lo} read.
  LD_MNN_IDX: FETCH_LO -> FETCH_HI -> WRITE_LO @nn idx[7:0] -> WRITE_HI @nn+1 idx[15:8] -> DONE.
  INC_MD/DEC_MD: FETCH_LO(d) -> READ_LO @ea -> MODIFY (exactly 1 cycle) -> WRITE_LO @ea result -> DONE.
  LD_MD_N: FETCH_LO(d) -> FETCH_HI(n) -> WRITE_LO @ea n -> DONE.
REQ-019 SHALL compute ea = idx + sign-extended d modulo 2^16; nn+1 SHALL wrap 0xFFFF -> 0x0000.
REQ-020 SHALL, in DONE, pulse done for one cycle, pulse ix_we (is_Y=0) or iy_we (is_Y=1) only for ops 0/1, and return to IDLE next cycle.
REQ-021 SHALL, in MODIFY, pulse flag_we with: S=r[7], Z=(r==0), H=INC:(m[3:0]==F) DEC:(m[3:0]==0), PV=INC:(r==0x80) DEC:(r==0x7F), N=0 INC/1 DEC; r = m±1 mod 256.
REQ-022 SHALL use the index value latched at start even if ix/iy change mid-operation.
REQ-023 SHALL hold busy=1 in every state except IDLE; start while busy SHALL be ignored.
REQ-024 SHALL allow unbounded mem_ack wait in any memory state with no timeout.

Reset
REQ-025 SHALL on rst_n=0 immediately enter IDLE and drive all outputs 0, including mid-transaction; an in-flight mem_req SHALL drop without completing.
REQ-026 SHALL after rst_n release accept start on the first rising edge.

Structure
REQ-027 SHALL place the op encoding and state encoding in shared package index_op_pkg.
REQ-028 SHALL implement INC/DEC result and flags in sub-module index_incdec_alu (8-bit, combinational).

Verification
REQ-029 LD_IDX_NN, is_Y=0, operands 0x34,0x12, ack same cycle -> ix_we with idx_wdata=0x1234, done 4 cycles after start, pc_inc twice.
REQ-030 INC_MD, IY=0x0005, d=0xFE, mem[0x0003]=0x7F -> read @0x0003, write 0x80, flags S=1,Z=0,H=1,PV=1,N=0.
REQ-031 LD_MNN_IDX, IX=0xBEEF, nn=0xFFFF, 3-cycle ack delay -> writes 0xEF@0xFFFF then 0xBE@0x0000, addr stable while waiting.
REQ-032 DEC_MD, IX=0x1000, d=0x10, mem=0x00 -> write 0xFF, flags S=1,Z=0,H=1,PV=0,N=1; second start during op ignored.
REQ-033 rst_n low during WRITE_LO of LD_MD_N -> mem_req, busy low same cycle, no done; next start runs normally.
